ifft_seq_ctrl: RTL

IFFT_SEQ_CTRL -- requirements
Module: ifft_seq_ctrl

---
 rtl/ifft_seq_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ifft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// ifft_seq_ctrl -- loader -> FFT -> drain frame sequencer with ack watchdog
// Revision: 1.0
// ============================================================================
module ifft_seq_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   err_clr,
  output logic                   slave_go,
  output logic                   fft_go,
  output logic                   master_go,
  input  logic                   slave_busy,
  input  logic                   fft_busy,
  input  logic                   master_busy,
  output logic [1:0]             bram_owner,
  output logic                   run_active,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   error,
  output logic [1:0]             error_stage
);

  localparam int WD_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  // The watchdog holds k-1 on the k-th ack cycle, so this value makes ERROR
  // appear exactly ACK_TIMEOUT cycles after the go pulse.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_LD_GO, S_LD_WAIT, S_FFT_GO, S_FFT_WAIT,
    S_DR_GO, S_DR_WAIT, S_FRAME_END, S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [FRAME_CNT_W-1:0] nf_q, nf_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic                   error_q, error_d;
  logic [1:0]             err_stage_q, err_stage_d;

  logic                   in_wait;
  logic                   wait_busy;
  logic [1:0]             wait_stage;
  state_t                 wait_next;
  logic [FRAME_CNT_W-1:0] fcnt_inc;

  assign fcnt_inc    = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
  assign frames_done = fcnt_q;
  assign error       = error_q;
  assign error_stage = err_stage_q;

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    wd_d        = wd_q;
    stop_pend_d = stop_pend_q;
    nf_d        = nf_q;
    fcnt_d      = fcnt_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    slave_go    = 1'b0;
    fft_go      = 1'b0;
    master_go   = 1'b0;
    bram_owner  = 2'd0;
    run_active  = 1'b1;
    frame_done  = 1'b0;
    in_wait     = 1'b0;
    wait_busy   = 1'b0;
    wait_stage  = 2'd0;
    wait_next   = S_IDLE;

    case (state_q)
      S_IDLE: begin
        run_active = 1'b0;
        if (start) begin
          state_d     = S_LD_GO;
          fcnt_d      = '0;
          stop_pend_d = 1'b0;
          nf_d        = num_frames;
        end
      end
      S_LD_GO: begin
        slave_go   = 1'b1;
        bram_owner = 2'd1;
        ack_d      = 1'b0;
        wd_d       = '0;
        state_d    = S_LD_WAIT;
      end
      S_LD_WAIT: begin
        bram_owner = 2'd1;
        in_wait    = 1'b1;
        wait_busy  = slave_busy;
        wait_stage = 2'd1;
        wait_next  = S_FFT_GO;
      end
      S_FFT_GO: begin
        fft_go     = 1'b1;
        bram_owner = 2'd2;
        ack_d      = 1'b0;
        wd_d       = '0;
        state_d    = S_FFT_WAIT;
      end
      S_FFT_WAIT: begin
        bram_owner = 2'd2;
        in_wait    = 1'b1;
        wait_busy  = fft_busy;
        wait_stage = 2'd2;
        wait_next  = S_DR_GO;
      end
      S_DR_GO: begin
        master_go  = 1'b1;
        bram_owner = 2'd3;
        ack_d      = 1'b0;
        wd_d       = '0;
        state_d    = S_DR_WAIT;
      end
      S_DR_WAIT: begin
        bram_owner = 2'd3;
        in_wait    = 1'b1;
        wait_busy  = master_busy;
        wait_stage = 2'd3;
        wait_next  = S_FRAME_END;
      end
      S_FRAME_END: begin
        frame_done = 1'b1;
        fcnt_d     = fcnt_inc;
        if (stop_pend_q || stop || ((nf_q != '0) && (fcnt_inc == nf_q)))
          state_d = S_IDLE;
        else
          state_d = S_LD_GO;
      end
      S_ERROR: begin
        run_active = 1'b0;
        if (err_clr) begin
          state_d     = S_IDLE;
          error_d     = 1'b0;
          err_stage_d = 2'd0;
        end
      end
      default: begin
        run_active = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Shared two-phase wait: ack phase under the watchdog, then busy falling.
    if (in_wait) begin
      if (!ack_q) begin
        if (wait_busy) begin
          ack_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_ERROR;
          error_d     = 1'b1;
          err_stage_d = wait_stage;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end else if (!wait_busy) begin
        state_d = wait_next;
      end
    end

    if (run_active && stop)
      stop_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      wd_q        <= '0;
      stop_pend_q <= 1'b0;
      nf_q        <= '0;
      fcnt_q      <= '0;
      error_q     <= 1'b0;
      err_stage_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      wd_q        <= wd_d;
      stop_pend_q <= stop_pend_d;
      nf_q        <= nf_d;
      fcnt_q      <= fcnt_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
    end
  end

endmodule
`default_nettype wire
